// File: rtl/btn_cond_defs_pkg.sv
// Shared definitions for the push-button conditioner: FSM state codes and default debounce time.
package btn_cond_defs;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_ARMING    = 2'd1;
   localparam logic [1:0] ST_PRESSED   = 2'd2;
   localparam logic [1:0] ST_DISARMING = 2'd3;

   // 10 ms at 12 MHz
   localparam int DEBOUNCE_CYCLES_DEFAULT = 120000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM with stability counter, level and strobes.
module btn_debounce_ch
   import btn_cond_defs::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = 17
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_raw,
   output logic       o_level,
   output logic       o_press,
   output logic       o_rel,
   output logic [1:0] o_state
);

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_press;
   logic             r_rel;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
      end
   end

   // Strobes default low each cycle so they can only ever last one clock.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_rel   <= 1'b0;
      end else begin
         r_press <= 1'b0;
         r_rel   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_sync2) begin
                  r_state <= ST_ARMING;
                  r_cnt   <= '0;
               end
            end
            ST_ARMING: begin
               if (!r_sync2) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_state <= ST_PRESSED;
                  r_level <= 1'b1;
                  r_press <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_PRESSED: begin
               if (!r_sync2) begin
                  r_state <= ST_DISARMING;
                  r_cnt   <= '0;
               end
            end
            ST_DISARMING: begin
               if (r_sync2) begin
                  r_state <= ST_PRESSED;
               end else if (r_cnt == LP_CNT_LAST) begin
                  r_state <= ST_IDLE;
                  r_level <= 1'b0;
                  r_rel   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_level = r_level;
   assign o_press = r_press;
   assign o_rel   = r_rel;
   assign o_state = r_state;

endmodule

// File: rtl/btn_conditioner.sv
// Stopwatch push-button front end: NUM_BTN fully independent debounce channels.
module btn_conditioner
   import btn_cond_defs::*;
#(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = 17
) (
   input  logic                 CLK,
   input  logic                 rst,
   input  logic [NUM_BTN-1:0]   btn_raw,
   output logic [NUM_BTN-1:0]   btn_level,
   output logic [NUM_BTN-1:0]   btn_press,
   output logic [NUM_BTN-1:0]   btn_rel,
   output logic [2*NUM_BTN-1:0] dbg_state
);

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .i_clk   (CLK),
         .i_rst   (rst),
         .i_raw   (btn_raw[g]),
         .o_level (btn_level[g]),
         .o_press (btn_press[g]),
         .o_rel   (btn_rel[g]),
         .o_state (dbg_state[2*g +: 2])
      );
   end

endmodule
